h_update: RTL and testbench

H_UPDATE -- requirements
Module: h_update

---
 rtl/h_update.sv | 228 ++++++++++++++++++++++
 tb/tb_h_update.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/h_update.sv
// h_update: pairs decayed state (dAh) with input contribution (dBx) beats
// through two alignment FIFOs and adds them lane-wise in FP16.

// Pipelined FP16 adder: combinational round-to-nearest-even add followed by
// LAT register stages; each stage only loads when a valid beat passes, so the
// final stage holds the last result between beats.
module fp16_add_wrapper #(
  parameter int unsigned LAT = 11
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [15:0]    r_dat [LAT];
  logic [LAT-2:0] r_vld;
  logic [15:0]    w_sum;

  function automatic logic is_nan(input logic [15:0] v);
    return (&v[14:10]) && (|v[9:0]);
  endfunction

  // IEEE binary16 add, RNE, 3 guard bits (guard/round/sticky); NaN is canonical 0x7E00
  function automatic logic [15:0] fp16_add(input logic [15:0] fa, input logic [15:0] fb);
    logic [15:0] x;
    logic [15:0] y;
    logic [13:0] mx;
    logic [13:0] my;
    logic [13:0] ms;
    logic [14:0] s;
    logic [14:0] r;
    logic [5:0]  ex;
    logic [5:0]  ey;
    logic [5:0]  d;
    logic [5:0]  e;
    logic [4:0]  ef;
    logic        up;
    if (is_nan(fa) || is_nan(fb)) return 16'h7E00;
    if (&fa[14:10] && &fb[14:10]) return (fa[15] == fb[15]) ? fa : 16'h7E00;
    if (&fa[14:10]) return fa;
    if (&fb[14:10]) return fb;
    // order operands so x has the larger magnitude
    if (fa[14:0] >= fb[14:0]) begin
      x = fa;
      y = fb;
    end else begin
      x = fb;
      y = fa;
    end
    ex = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
    ey = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
    mx = {|x[14:10], x[9:0], 3'b000};
    my = {|y[14:10], y[9:0], 3'b000};
    d  = ex - ey;
    if (d >= 6'd14) begin
      ms = {13'd0, |my};
    end else begin
      ms = my >> d;
      ms[0] = ms[0] | (|(my & ((14'd1 << d) - 14'd1)));
    end
    if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, ms};
    else                s = {1'b0, mx} - {1'b0, ms};
    if (s == 15'd0) return {x[15] & y[15], 15'd0};
    e = ex;
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (!s[13] && (e > 6'd1)) begin
          s = s << 1;
          e = e - 6'd1;
        end
      end
    end
    if (e >= 6'd31) return {x[15], 15'h7C00};
    ef = s[13] ? e[4:0] : 5'd0;
    up = s[2] && (s[1] || s[0] || s[3]);
    // rounding carry propagates naturally into the exponent field
    r  = {ef, s[12:3]} + 15'(up);
    return {x[15], r};
  endfunction

  // combinational add of the issued operands
  always_comb begin
    w_sum = fp16_add(a, b);
  end

  // per-stage valid bits, used only as load enables for the data stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= valid_in;
      for (int i = 1; i < LAT - 1; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // data stages, not reset
  always_ff @(posedge clk) begin
    if (valid_in) r_dat[0] <= w_sum;
    for (int i = 1; i < LAT; i++) begin
      if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
    end
  end

  assign sum = r_dat[LAT-1];

endmodule

module h_update #(
  parameter int unsigned DW            = 16,
  parameter int unsigned N_TILE        = 16,
  parameter int unsigned ADD_LAT       = 11,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TILES_PER_ROW = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    dAh_valid_i,
  input  logic [N_TILE*DW-1:0]    dAh_i,
  input  logic                    dBx_valid_i,
  input  logic [N_TILE*DW-1:0]    dBx_i,
  output logic [N_TILE*DW-1:0]    h_o,
  output logic                    valid_o,
  output logic [((TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1)-1:0] h_idx_o,
  output logic                    h_last_o,
  output logic                    ovf_o
);

  localparam int unsigned W  = N_TILE * DW;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = (TILES_PER_ROW > 1) ? $clog2(TILES_PER_ROW) : 1;

  logic [W-1:0]       r_a_mem [FIFO_DEPTH];
  logic [W-1:0]       r_b_mem [FIFO_DEPTH];
  logic [AW:0]        r_a_wp, r_a_rp, r_b_wp, r_b_rp;
  logic [W-1:0]       r_opa, r_opb;
  logic               r_issue;
  logic [ADD_LAT-1:0] r_vsr;
  logic [IW-1:0]      r_idx;
  logic               r_last;
  logic               r_ovf;

  logic               w_a_empty, w_b_empty, w_a_full, w_b_full;
  logic               w_pop, w_a_wr, w_b_wr, w_ovf_set;
  logic [IW-1:0]      w_idx_nxt;

  // FIFO status, pop pairing and write acceptance
  always_comb begin
    w_a_empty = (r_a_wp == r_a_rp);
    w_b_empty = (r_b_wp == r_b_rp);
    w_a_full  = (r_a_wp[AW] != r_a_rp[AW]) && (r_a_wp[AW-1:0] == r_a_rp[AW-1:0]);
    w_b_full  = (r_b_wp[AW] != r_b_rp[AW]) && (r_b_wp[AW-1:0] == r_b_rp[AW-1:0]);
    // status is registered, so a beat written this cycle cannot pop this cycle
    w_pop     = !w_a_empty && !w_b_empty;
    w_a_wr    = dAh_valid_i && (!w_a_full || w_pop);
    w_b_wr    = dBx_valid_i && (!w_b_full || w_pop);
    w_ovf_set = (dAh_valid_i && w_a_full && !w_pop) ||
                (dBx_valid_i && w_b_full && !w_pop);
  end

  // next row index after the beat currently on the output
  always_comb begin
    w_idx_nxt = r_idx;
    if (r_vsr[ADD_LAT-1]) begin
      w_idx_nxt = (r_idx == IW'(TILES_PER_ROW - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  // FIFO storage and operand registers (data only, not reset)
  always_ff @(posedge clk) begin
    if (w_a_wr) r_a_mem[r_a_wp[AW-1:0]] <= dAh_i;
    if (w_b_wr) r_b_mem[r_b_wp[AW-1:0]] <= dBx_i;
    if (w_pop) begin
      r_opa <= r_a_mem[r_a_rp[AW-1:0]];
      r_opb <= r_b_mem[r_b_rp[AW-1:0]];
    end
  end

  // pointers, issue strobe, valid pipeline, row counter and overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_wp  <= '0;
      r_a_rp  <= '0;
      r_b_wp  <= '0;
      r_b_rp  <= '0;
      r_issue <= 1'b0;
      r_vsr   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_a_wr) r_a_wp <= r_a_wp + (AW+1)'(1);
      if (w_b_wr) r_b_wp <= r_b_wp + (AW+1)'(1);
      if (w_pop) begin
        r_a_rp <= r_a_rp + (AW+1)'(1);
        r_b_rp <= r_b_rp + (AW+1)'(1);
      end
      r_issue <= w_pop;
      r_vsr   <= {r_vsr[ADD_LAT-2:0], r_issue};
      r_idx   <= w_idx_nxt;
      r_last  <= r_vsr[ADD_LAT-2] && (w_idx_nxt == IW'(TILES_PER_ROW - 1));
      if (w_ovf_set) r_ovf <= 1'b1;
    end
  end

  // lane-wise FP16 adders
  for (genvar n = 0; n < N_TILE; n++) begin : g_lane
    fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
      .clk      (clk),
      .rstn     (rstn),
      .valid_in (r_issue),
      .a        (r_opa[n*DW +: DW]),
      .b        (r_opb[n*DW +: DW]),
      .sum      (h_o[n*DW +: DW])
    );
  end

  assign valid_o  = r_vsr[ADD_LAT-1];
  assign h_idx_o  = r_idx;
  assign h_last_o = r_last;
  assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_h_update.sv
// Directed bench for h_update: latency, skew, overflow, row wrap,
// FP16 corner cases and mid-flight reset.
module tb_h_update;

  localparam int unsigned DW  = 16;
  localparam int unsigned NT  = 16;
  localparam int unsigned LAT = 11;
  localparam int unsigned FD  = 4;
  localparam int unsigned TPR = 8;
  localparam int unsigned W   = NT * DW;

  logic         clk = 1'b0;
  logic         rstn;
  logic         dAh_valid_i, dBx_valid_i;
  logic [W-1:0] dAh_i, dBx_i;
  logic [W-1:0] h_o;
  logic         valid_o;
  logic [2:0]   h_idx_o;
  logic         h_last_o;
  logic         ovf_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;

  typedef struct {
    logic [W-1:0] h;
    logic [2:0]   idx;
    logic         last;
    int           cyc;
  } obs_t;
  obs_t q[$];

  // 1..8 as FP16; adding 1.0 gives 2..9
  logic [15:0] A [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                         16'h4500, 16'h4600, 16'h4700, 16'h4800};
  logic [15:0] E [8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500,
                         16'h4600, 16'h4700, 16'h4800, 16'h4880};

  h_update #(.DW(DW), .N_TILE(NT), .ADD_LAT(LAT), .FIFO_DEPTH(FD), .TILES_PER_ROW(TPR)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .dAh_valid_i (dAh_valid_i),
    .dAh_i       (dAh_i),
    .dBx_valid_i (dBx_valid_i),
    .dBx_i       (dBx_i),
    .h_o         (h_o),
    .valid_o     (valid_o),
    .h_idx_o     (h_idx_o),
    .h_last_o    (h_last_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // capture every output beat with its cycle stamp
  always @(negedge clk) begin
    if (valid_o) q.push_back('{h: h_o, idx: h_idx_o, last: h_last_o, cyc: cyc});
  end

  function automatic logic [W-1:0] vec(input logic [15:0] v);
    return {NT{v}};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    dAh_valid_i = 1'b0;
    dBx_valid_i = 1'b0;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] ea, eb, ee;
    rstn = 1'b0;
    idle();
    dAh_i = '0;
    dBx_i = '0;
    tick();
    tick();
    check("rst_valid", W'(valid_o), W'(1'b0));
    check("rst_last",  W'(h_last_o), W'(1'b0));
    check("rst_idx",   W'(h_idx_o), W'(0));
    check("rst_ovf",   W'(ovf_o), W'(1'b0));

    // single pair presented in the cycle rstn releases
    rstn = 1'b1;
    q.delete();
    t0 = cyc;
    dAh_valid_i = 1'b1; dAh_i = vec(16'h3C00);
    dBx_valid_i = 1'b1; dBx_i = vec(16'h4000);
    tick();
    idle();
    repeat (LAT + 6) tick();
    check("single_count", W'(q.size()), W'(1));
    if (q.size() > 0) begin
      check("single_lat",  W'(q[0].cyc - t0), W'(LAT + 2));
      check("single_data", q[0].h, vec(16'h4200));
      check("single_idx",  W'(q[0].idx), W'(0));
      check("single_last", W'(q[0].last), W'(1'b0));
    end
    check("single_hold", h_o, vec(16'h4200));
    check("single_idx_after", W'(h_idx_o), W'(1));

    // skew: dAh beats 0..3 in cycles 0..3, dBx beats 0..3 in cycles 5..8
    do_reset();
    q.delete();
    t0 = cyc;
    for (int c = 0; c < 9; c++) begin
      dAh_valid_i = (c < 4);
      dAh_i       = vec(A[c % 8]);
      dBx_valid_i = (c >= 5);
      dBx_i       = vec(16'h3C00);
      tick();
    end
    idle();
    repeat (LAT + 6) tick();
    check("skew_count", W'(q.size()), W'(4));
    for (int k = 0; k < 4 && k < q.size(); k++) begin
      check("skew_data", q[k].h, vec(E[k]));
      check("skew_cyc",  W'(q[k].cyc - t0), W'(5 + LAT + 2 + k));
      check("skew_idx",  W'(q[k].idx), W'(k));
    end
    check("skew_ovf", W'(ovf_o), W'(1'b0));

    // overflow: five dAh beats with dBx idle
    do_reset();
    q.delete();
    for (int c = 0; c < 5; c++) begin
      dAh_valid_i = 1'b1;
      dAh_i       = vec(A[c]);
      if (c == 4) check("ovf_before_5th", W'(ovf_o), W'(1'b0));
      tick();
    end
    idle();
    check("ovf_set", W'(ovf_o), W'(1'b1));
    for (int c = 0; c < 4; c++) begin
      dBx_valid_i = 1'b1;
      dBx_i       = vec(16'h3C00);
      tick();
    end
    idle();
    repeat (LAT + 8) tick();
    check("ovf_count", W'(q.size()), W'(4));
    for (int k = 0; k < 4 && k < q.size(); k++) begin
      check("ovf_data", q[k].h, vec(E[k]));
    end
    check("ovf_sticky", W'(ovf_o), W'(1'b1));

    // row wrap: 16 back-to-back pairs
    do_reset();
    q.delete();
    t0 = cyc;
    for (int i = 0; i < 2 * TPR; i++) begin
      dAh_valid_i = 1'b1; dAh_i = vec(A[i % 8]);
      dBx_valid_i = 1'b1; dBx_i = vec(16'h3C00);
      tick();
    end
    idle();
    repeat (LAT + 6) tick();
    check("row_count", W'(q.size()), W'(2 * TPR));
    for (int i = 0; i < 2 * TPR && i < q.size(); i++) begin
      check("row_idx",  W'(q[i].idx), W'(i % TPR));
      check("row_last", W'(q[i].last), W'((i % TPR) == TPR - 1));
      check("row_data", q[i].h, vec(E[i % 8]));
      check("row_cyc",  W'(q[i].cyc - t0), W'(LAT + 2 + i));
    end
    check("row_idx_wrapped", W'(h_idx_o), W'(0));

    // FP16 corner cases, one per lane
    do_reset();
    q.delete();
    ea = vec(16'h4400);
    eb = vec(16'h4400);
    ee = vec(16'h4800);
    ea[0*16 +: 16] = 16'h7C00; eb[0*16 +: 16] = 16'hFC00; ee[0*16 +: 16] = 16'h7E00;
    ea[1*16 +: 16] = 16'h8000; eb[1*16 +: 16] = 16'h0000; ee[1*16 +: 16] = 16'h0000;
    ea[2*16 +: 16] = 16'h3C00; eb[2*16 +: 16] = 16'h3C00; ee[2*16 +: 16] = 16'h4000;
    ea[3*16 +: 16] = 16'h3C00; eb[3*16 +: 16] = 16'hBC00; ee[3*16 +: 16] = 16'h0000;
    ea[4*16 +: 16] = 16'h7BFF; eb[4*16 +: 16] = 16'h7BFF; ee[4*16 +: 16] = 16'h7C00;
    ea[5*16 +: 16] = 16'h0001; eb[5*16 +: 16] = 16'h0001; ee[5*16 +: 16] = 16'h0002;
    ea[6*16 +: 16] = 16'h3C00; eb[6*16 +: 16] = 16'h1000; ee[6*16 +: 16] = 16'h3C00;
    ea[7*16 +: 16] = 16'h3C01; eb[7*16 +: 16] = 16'h1000; ee[7*16 +: 16] = 16'h3C02;
    dAh_valid_i = 1'b1; dAh_i = ea;
    dBx_valid_i = 1'b1; dBx_i = eb;
    tick();
    idle();
    repeat (LAT + 6) tick();
    check("edge_count", W'(q.size()), W'(1));
    if (q.size() > 0) check("edge_data", q[0].h, ee);

    // reset three cycles after issuing a pair drops it
    do_reset();
    q.delete();
    dAh_valid_i = 1'b1; dAh_i = vec(16'h3C00);
    dBx_valid_i = 1'b1; dBx_i = vec(16'h3C00);
    tick();
    idle();
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    repeat (LAT + 4) tick();
    check("midrst_count", W'(q.size()), W'(0));
    check("midrst_idx",   W'(h_idx_o), W'(0));
    check("midrst_valid", W'(valid_o), W'(1'b0));
    // FIFOs must be empty: a fresh pair yields exactly one beat at nominal latency
    q.delete();
    t0 = cyc;
    dAh_valid_i = 1'b1; dAh_i = vec(16'h4400);
    dBx_valid_i = 1'b1; dBx_i = vec(16'h4000);
    tick();
    idle();
    repeat (LAT + 6) tick();
    check("midrst_fresh_count", W'(q.size()), W'(1));
    if (q.size() > 0) begin
      check("midrst_fresh_data", q[0].h, vec(16'h4600));
      check("midrst_fresh_lat",  W'(q[0].cyc - t0), W'(LAT + 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
